// File: rtl/retire_trace_fifo.sv
// Captures one trace record per retired instruction and drains it as four 32-bit words.
// Latency: a record written at edge N presents W0 on out_data in the cycle after N.
// Backpressure: out_data holds while out_ready is low; when full, new records are dropped and counted.
module retire_trace_fifo #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trace_en,
  input  logic        retire_valid,
  input  logic [31:0] retire_pc,
  input  logic [6:0]  retire_op,
  input  logic [4:0]  retire_rd,
  input  logic        retire_regwrite,
  input  logic [31:0] retire_result,
  input  logic        retire_dmem_we,
  input  logic [31:0] retire_dmem_addr,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic [15:0] drop_count,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int AW = $clog2(DEPTH);

  // Each entry holds the four output words pre-formatted; [0] is W0 (pc).
  logic [3:0][31:0] mem [DEPTH];

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [1:0]   wi;
  logic [15:0]  seq;
  logic         ovf_pend;

  logic         full;
  logic         empty;
  logic         capture;
  logic         push;
  logic         drop;
  logic         xfer;
  logic         pop;
  logic [31:0]  rec_w1;
  logic [31:0]  rec_w2;
  logic [3:0][31:0] new_rec;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign capture = retire_valid && trace_en;
  assign push    = capture && !full;
  assign drop    = capture && full;

  assign out_valid  = !empty;
  assign xfer       = out_valid && out_ready;
  assign pop        = xfer && (wi == 2'd3);
  assign out_last   = out_valid && (wi == 2'd3);
  assign fifo_level = wr_ptr - rd_ptr;

  // Output word is a plain read of the head entry, so async reset clears it at once.
  assign out_data = out_valid ? mem[rd_ptr[AW-1:0]][wi] : 32'h0;

  assign rec_w1  = {seq, retire_op, retire_rd, retire_regwrite, retire_dmem_we, ovf_pend, 1'b0};
  assign rec_w2  = retire_regwrite ? retire_result : 32'h0;
  assign new_rec = {retire_dmem_addr, rec_w2, rec_w1, retire_pc};

  // Record storage; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= new_rec;
    end
  end

  // Write side: pointer, sequence number, overflow tagging and drop counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      seq        <= 16'h0;
      ovf_pend   <= 1'b0;
      drop_count <= 16'h0;
    end else begin
      if (capture) begin
        seq <= seq + 16'd1;
      end
      if (push) begin
        wr_ptr   <= wr_ptr + (AW+1)'(1);
        ovf_pend <= 1'b0;
      end
      if (drop) begin
        ovf_pend <= 1'b1;
        if (drop_count != 16'hFFFF) begin
          drop_count <= drop_count + 16'd1;
        end
      end
    end
  end

  // Read side: word serializer; the head pops after its last word transfers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wi     <= 2'd0;
    end else if (xfer) begin
      wi <= wi + 2'd1;
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_retire_trace_fifo.sv
module tb_retire_trace_fifo;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trace_en = 1'b0;
  logic        retire_valid = 1'b0;
  logic [31:0] retire_pc = '0;
  logic [6:0]  retire_op = '0;
  logic [4:0]  retire_rd = '0;
  logic        retire_regwrite = 1'b0;
  logic [31:0] retire_result = '0;
  logic        retire_dmem_we = 1'b0;
  logic [31:0] retire_dmem_addr = '0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready = 1'b0;
  logic [15:0] drop_count;
  logic [3:0]  fifo_level;

  int checks = 0;
  int errors = 0;

  retire_trace_fifo #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .trace_en         (trace_en),
    .retire_valid     (retire_valid),
    .retire_pc        (retire_pc),
    .retire_op        (retire_op),
    .retire_rd        (retire_rd),
    .retire_regwrite  (retire_regwrite),
    .retire_result    (retire_result),
    .retire_dmem_we   (retire_dmem_we),
    .retire_dmem_addr (retire_dmem_addr),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_last         (out_last),
    .out_ready        (out_ready),
    .drop_count       (drop_count),
    .fifo_level       (fifo_level)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] res;
    logic        we;
    logic [31:0] addr;
    logic [15:0] seq;
    logic        ovf;
  } rec_t;

  rec_t        q[$];
  int          m_wi;
  logic [15:0] m_seq;
  int          m_drops;
  logic        m_ovf;

  function automatic logic [31:0] exp_word(rec_t r, int idx);
    case (idx)
      0:       return r.pc;
      1:       return {r.seq, r.op, r.rd, r.rw, r.we, r.ovf, 1'b0};
      2:       return r.rw ? r.res : 32'h0;
      default: return r.addr;
    endcase
  endfunction

  function automatic logic [31:0] m_data();
    if (q.size() == 0) return 32'h0;
    return exp_word(q[0], m_wi);
  endfunction

  task automatic model_clear();
    q.delete();
    m_wi = 0;
    m_seq = 16'h0;
    m_drops = 0;
    m_ovf = 1'b0;
  endtask

  // Applies the effect of one clock edge using the inputs driven for it.
  task automatic model_edge();
    int   lvl;
    rec_t r;
    lvl = q.size();
    if (retire_valid && trace_en) begin
      if (lvl < DEPTH) begin
        r.pc = retire_pc; r.op = retire_op; r.rd = retire_rd;
        r.rw = retire_regwrite; r.res = retire_result; r.we = retire_dmem_we;
        r.addr = retire_dmem_addr; r.seq = m_seq; r.ovf = m_ovf;
        q.push_back(r);
        m_ovf = 1'b0;
      end else begin
        if (m_drops < 65535) m_drops++;
        m_ovf = 1'b1;
      end
      m_seq = m_seq + 16'd1;
    end
    if (lvl > 0 && out_ready) begin
      if (m_wi == 3) begin
        void'(q.pop_front());
        m_wi = 0;
      end else begin
        m_wi++;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic rand_fields();
    retire_pc        = $urandom;
    retire_op        = 7'($urandom);
    retire_rd        = 5'($urandom);
    retire_regwrite  = 1'($urandom);
    retire_result    = $urandom;
    retire_dmem_we   = 1'($urandom);
    retire_dmem_addr = $urandom;
  endtask

  // Drive one cycle of inputs, let the edge happen, return at the following negedge.
  task automatic cycle(input bit cap, input bit en, input bit rdy);
    retire_valid = cap;
    trace_en     = en;
    out_ready    = rdy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    retire_valid = 1'b0;
    trace_en     = 1'b0;
    out_ready    = 1'b0;
    reset        = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %0b want 0", out_last); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drops got %0d want 0", drop_count); end
  endtask

  task automatic set_directed();
    retire_pc = 32'h10; retire_op = 7'h33; retire_rd = 5'd5; retire_regwrite = 1'b1;
    retire_result = 32'hDEADBEEF; retire_dmem_we = 1'b0; retire_dmem_addr = 32'h0;
  endtask

  task automatic test_single();
    logic [31:0] exp [4];
    exp[0] = 32'h00000010; exp[1] = 32'h00006658; exp[2] = 32'hDEADBEEF; exp[3] = 32'h0;
    do_reset();
    set_directed();
    cycle(1, 1, 1);
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== exp[i]) begin
        errors++; $display("FAIL single_w%0d got v=%0b %h want v=1 %h", i, out_valid, out_data, exp[i]);
      end
      checks++; if (out_last !== (i == 3)) begin
        errors++; $display("FAIL single_last%0d got %0b want %0b", i, out_last, (i == 3));
      end
      cycle(0, 1, 1);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_empty got %0b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp [4];
    exp[0] = 32'h00000010; exp[1] = 32'h00016658; exp[2] = 32'hDEADBEEF; exp[3] = 32'h0;
    set_directed();
    cycle(1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_data !== 32'h10 || out_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold%0d got v=%0b %h want v=1 00000010", i, out_valid, out_data);
      end
      cycle(0, 1, 0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_data !== exp[i] || out_last !== (i == 3)) begin
        errors++; $display("FAIL stall_w%0d got %h last=%0b want %h", i, out_data, out_last, exp[i]);
      end
      cycle(0, 1, 1);
    end
  endtask

  task automatic test_overflow();
    int nrec;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      rand_fields();
      cycle(1, 1, 0);
    end
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL ovf_level got %0d want 8", fifo_level); end
    checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL ovf_drops got %0d want 2", drop_count); end
    nrec = 0;
    for (int i = 0; i < 40 && out_valid; i++) begin
      checks++; if (out_data !== m_data()) begin
        errors++; $display("FAIL ovf_drain got %h want %h", out_data, m_data());
      end
      if (m_wi == 1) begin
        checks++; if (out_data[31:16] !== 16'(nrec) || out_data[1] !== 1'b0) begin
          errors++; $display("FAIL ovf_seq%0d got seq=%0d ovf=%0b want seq=%0d ovf=0", nrec, out_data[31:16], out_data[1], nrec);
        end
        nrec++;
      end
      cycle(0, 1, 1);
    end
    checks++; if (nrec !== 8 || out_valid !== 1'b0) begin
      errors++; $display("FAIL ovf_count got %0d records v=%0b want 8 v=0", nrec, out_valid);
    end
    rand_fields();
    cycle(1, 1, 1);
    cycle(0, 1, 1);
    checks++; if (out_data[31:16] !== 16'd10 || out_data[1] !== 1'b1) begin
      errors++; $display("FAIL ovf_tag got seq=%0d ovf=%0b want seq=10 ovf=1", out_data[31:16], out_data[1]);
    end
    repeat (4) cycle(0, 1, 1);
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      rand_fields();
      cycle(1, 1, 0);
    end
    repeat (3) cycle(0, 1, 1);
    checks++; if (out_last !== 1'b1 || fifo_level !== 4'd8) begin
      errors++; $display("FAIL fullpop_pre got last=%0b level=%0d want last=1 level=8", out_last, fifo_level);
    end
    rand_fields();
    cycle(1, 1, 1);
    checks++; if (fifo_level !== 4'd7) begin errors++; $display("FAIL fullpop_level got %0d want 7", fifo_level); end
    checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL fullpop_drops got %0d want 1", drop_count); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rand_fields();
      cycle($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7);
      checks++; if (out_valid !== (q.size() != 0) || out_data !== m_data() ||
                    out_last !== (q.size() != 0 && m_wi == 3)) begin
        errors++; $display("FAIL rand_out cyc %0d got v=%0b %h l=%0b want v=%0b %h", i, out_valid, out_data, out_last, (q.size() != 0), m_data());
      end
      checks++; if (fifo_level !== 4'(q.size()) || drop_count !== 16'(m_drops)) begin
        errors++; $display("FAIL rand_cnt cyc %0d got lvl=%0d drop=%0d want lvl=%0d drop=%0d", i, fifo_level, drop_count, q.size(), m_drops);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 65535; i++) begin
      rand_fields();
      cycle(1, 1, 1);
    end
    checks++; if (fifo_level !== 4'(q.size()) || drop_count !== 16'(m_drops)) begin
      errors++; $display("FAIL wrap_preload got lvl=%0d drop=%0d want lvl=%0d drop=%0d", fifo_level, drop_count, q.size(), m_drops);
    end
    for (int i = 0; i < 64 && out_valid; i++) cycle(0, 1, 1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_drain got v=%0b want 0", out_valid); end
    rand_fields(); cycle(1, 1, 0);
    rand_fields(); cycle(1, 1, 0);
    rand_fields(); cycle(1, 0, 0);
    checks++; if (fifo_level !== 4'd2) begin errors++; $display("FAIL wrap_level got %0d want 2", fifo_level); end
    cycle(0, 1, 1);
    checks++; if (out_data[31:16] !== 16'hFFFF) begin errors++; $display("FAIL wrap_seq0 got %h want ffff", out_data[31:16]); end
    repeat (4) cycle(0, 1, 1);
    checks++; if (out_data[31:16] !== 16'h0000) begin errors++; $display("FAIL wrap_seq1 got %h want 0000", out_data[31:16]); end
    repeat (3) cycle(0, 1, 1);
    rand_fields(); cycle(1, 1, 1);
    cycle(0, 1, 1);
    checks++; if (out_data[31:16] !== 16'h0001) begin errors++; $display("FAIL wrap_en_off got %h want 0001", out_data[31:16]); end
    repeat (3) cycle(0, 1, 1);
  endtask

  task automatic test_async_reset();
    logic [31:0] pc0;
    do_reset();
    rand_fields();
    cycle(1, 1, 0);
    cycle(0, 1, 1);
    checks++; if (out_data !== m_data()) begin errors++; $display("FAIL areset_w1 got %h want %h", out_data, m_data()); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_last !== 1'b0) begin
      errors++; $display("FAIL areset_now got v=%0b %h l=%0b want 0 0 0", out_valid, out_data, out_last);
    end
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    checks++; if (fifo_level !== 4'd0 || drop_count !== 16'd0) begin
      errors++; $display("FAIL areset_after got lvl=%0d drop=%0d want 0 0", fifo_level, drop_count);
    end
    rand_fields();
    pc0 = retire_pc;
    cycle(1, 1, 1);
    checks++; if (out_data !== pc0) begin errors++; $display("FAIL areset_w0 got %h want %h", out_data, pc0); end
    cycle(0, 1, 1);
    checks++; if (out_data[31:16] !== 16'h0) begin errors++; $display("FAIL areset_seq got %h want 0000", out_data[31:16]); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_full_pop();
    test_random();
    test_async_reset();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
